// File: rtl/daxi_master.sv
// Data-side AXI4-Lite master: posted-store write buffer plus ordered single loads.
// Optional sticky bus-error capture is enabled by defining KRV_DAXI_ERR_CAPTURE_EN.
module daxi_master #(
   parameter int WBUF_DEPTH = 4,
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32
) (
   input  logic                cpu_clk,
   input  logic                cpu_rstn,
   input  logic                DAXI_access,
   input  logic                DAXI_rd0_wr1,
   input  logic [DATA_W/8-1:0] DAXI_byte_strobe,
   input  logic [DATA_W-1:0]   DAXI_write_data,
   input  logic [31:0]         DAXI_addr,
   output logic                DAXI_trans_buffer_full,
   output logic [DATA_W-1:0]   DAXI_read_data,
   output logic                DAXI_read_data_valid,
   output logic                m_awvalid,
   input  logic                m_awready,
   output logic [ADDR_W-1:0]   m_awaddr,
   output logic                m_wvalid,
   input  logic                m_wready,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   input  logic                m_bvalid,
   output logic                m_bready,
   input  logic [1:0]          m_bresp,
   output logic                m_arvalid,
   input  logic                m_arready,
   output logic [ADDR_W-1:0]   m_araddr,
   input  logic                m_rvalid,
   output logic                m_rready,
   input  logic [DATA_W-1:0]   m_rdata,
   input  logic [1:0]          m_rresp,
   output logic                daxi_err,
   output logic [31:0]         daxi_err_addr
);

   localparam int PW = $clog2(WBUF_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = DATA_W / 8;

   typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_ORDER, R_ADDR, R_DATA} rstate_t;

   wstate_t wstate;
   rstate_t rstate;

   logic [ADDR_W-1:0] wb_addr [WBUF_DEPTH];
   logic [SW-1:0]     wb_strb [WBUF_DEPTH];
   logic [DATA_W-1:0] wb_data [WBUF_DEPTH];

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] snap;
   logic          aw_done;
   logic          w_done;

   logic push;
   logic pop;
   logic aw_fin;
   logic w_fin;
   logic b_done;
   logic r_done;
   logic ld_acc;

   assign DAXI_trans_buffer_full = (count == CW'(WBUF_DEPTH));
   assign push   = DAXI_access & DAXI_rd0_wr1 & ~DAXI_trans_buffer_full;
   assign aw_fin = aw_done | (m_awvalid & m_awready);
   assign w_fin  = w_done | (m_wvalid & m_wready);
   assign pop    = (wstate == W_REQ) & aw_fin & w_fin;
   assign b_done = (wstate == W_RESP) & m_bvalid;
   assign r_done = (rstate == R_DATA) & m_rvalid;
   assign ld_acc = DAXI_access & ~DAXI_rd0_wr1 & (rstate == R_IDLE);

   // Buffer storage: written at the tail on every accepted store.
   always_ff @(posedge cpu_clk) begin
      if (push) begin
         wb_addr[wr_ptr] <= DAXI_addr[ADDR_W-1:0];
         wb_strb[wr_ptr] <= DAXI_byte_strobe;
         wb_data[wr_ptr] <= DAXI_write_data;
      end
   end

   // Buffer pointers and occupancy; push and pop together leave count unchanged.
   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Write FSM: one outstanding write, AW and W complete independently.
   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         wstate    <= W_IDLE;
         m_awvalid <= 1'b0;
         m_wvalid  <= 1'b0;
         m_bready  <= 1'b0;
         m_awaddr  <= '0;
         m_wdata   <= '0;
         m_wstrb   <= '0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
      end else begin
         unique case (wstate)
            W_IDLE: begin
               if (count != '0) begin
                  m_awaddr  <= wb_addr[rd_ptr];
                  m_wdata   <= wb_data[rd_ptr];
                  m_wstrb   <= wb_strb[rd_ptr];
                  m_awvalid <= 1'b1;
                  m_wvalid  <= 1'b1;
                  aw_done   <= 1'b0;
                  w_done    <= 1'b0;
                  wstate    <= W_REQ;
               end
            end
            W_REQ: begin
               if (m_awvalid && m_awready) begin
                  m_awvalid <= 1'b0;
                  aw_done   <= 1'b1;
               end
               if (m_wvalid && m_wready) begin
                  m_wvalid <= 1'b0;
                  w_done   <= 1'b1;
               end
               if (aw_fin && w_fin) begin
                  m_bready <= 1'b1;
                  wstate   <= W_RESP;
               end
            end
            W_RESP: begin
               if (m_bvalid) begin
                  m_bready <= 1'b0;
                  wstate   <= W_IDLE;
               end
            end
            default: wstate <= W_IDLE;
         endcase
      end
   end

   // Read FSM: a load waits until every store present at its accept has its B response.
   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         rstate               <= R_IDLE;
         m_arvalid            <= 1'b0;
         m_rready             <= 1'b0;
         m_araddr             <= '0;
         snap                 <= '0;
         DAXI_read_data       <= '0;
         DAXI_read_data_valid <= 1'b0;
      end else begin
         DAXI_read_data_valid <= 1'b0;
         unique case (rstate)
            R_IDLE: begin
               if (ld_acc) begin
                  m_araddr <= DAXI_addr[ADDR_W-1:0];
                  snap     <= count + CW'(wstate == W_RESP && !m_bvalid);
                  rstate   <= R_ORDER;
               end
            end
            R_ORDER: begin
               if (snap == '0) begin
                  m_arvalid <= 1'b1;
                  rstate    <= R_ADDR;
               end else if (b_done) begin
                  snap <= snap - 1'b1;
               end
            end
            R_ADDR: begin
               if (m_arready) begin
                  m_arvalid <= 1'b0;
                  m_rready  <= 1'b1;
                  rstate    <= R_DATA;
               end
            end
            R_DATA: begin
               if (m_rvalid) begin
                  m_rready             <= 1'b0;
                  DAXI_read_data       <= m_rdata;
                  DAXI_read_data_valid <= 1'b1;
                  rstate               <= R_IDLE;
               end
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end

`ifdef KRV_DAXI_ERR_CAPTURE_EN
   // Sticky error flag; address latched from the first failing transaction only.
   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         daxi_err      <= 1'b0;
         daxi_err_addr <= '0;
      end else if (!daxi_err) begin
         if (b_done && m_bresp != 2'b00) begin
            daxi_err      <= 1'b1;
            daxi_err_addr <= 32'(m_awaddr);
         end else if (r_done && m_rresp != 2'b00) begin
            daxi_err      <= 1'b1;
            daxi_err_addr <= 32'(m_araddr);
         end
      end
   end
`else
   logic unused_resp;
   assign unused_resp   = ^{m_bresp, m_rresp, r_done};
   assign daxi_err      = 1'b0;
   assign daxi_err_addr = '0;
`endif

endmodule

// File: tb/tb_daxi_master.sv
// Directed bench for daxi_master with a small AXI4-Lite slave model.
// Error-capture checks follow KRV_DAXI_ERR_CAPTURE_EN.
module tb_daxi_master;

   logic        cpu_clk = 1'b0;
   logic        cpu_rstn = 1'b0;
   logic        DAXI_access = 1'b0;
   logic        DAXI_rd0_wr1 = 1'b0;
   logic [3:0]  DAXI_byte_strobe = 4'h0;
   logic [31:0] DAXI_write_data = 32'h0;
   logic [31:0] DAXI_addr = 32'h0;
   logic        DAXI_trans_buffer_full;
   logic [31:0] DAXI_read_data;
   logic        DAXI_read_data_valid;
   logic        m_awvalid;
   logic        m_awready = 1'b1;
   logic [31:0] m_awaddr;
   logic        m_wvalid;
   logic        m_wready = 1'b1;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_bvalid = 1'b0;
   logic        m_bready;
   logic [1:0]  m_bresp = 2'b00;
   logic        m_arvalid;
   logic        m_arready = 1'b1;
   logic [31:0] m_araddr;
   logic        m_rvalid = 1'b0;
   logic        m_rready;
   logic [31:0] m_rdata = 32'h0;
   logic [1:0]  m_rresp = 2'b00;
   logic        daxi_err;
   logic [31:0] daxi_err_addr;

   daxi_master dut (
      .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
      .DAXI_access(DAXI_access), .DAXI_rd0_wr1(DAXI_rd0_wr1),
      .DAXI_byte_strobe(DAXI_byte_strobe), .DAXI_write_data(DAXI_write_data),
      .DAXI_addr(DAXI_addr), .DAXI_trans_buffer_full(DAXI_trans_buffer_full),
      .DAXI_read_data(DAXI_read_data), .DAXI_read_data_valid(DAXI_read_data_valid),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
      .daxi_err(daxi_err), .daxi_err_addr(daxi_err_addr)
   );

   always #5 cpu_clk = ~cpu_clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int b_cnt = 0;
   int b_cyc = 0;
   int ar_cyc = 0;
   int b_delay = 0;
   logic r_hold = 1'b0;
   logic [1:0] bresp_cfg = 2'b00;
   logic [1:0] rresp_cfg = 2'b00;

   logic [31:0] aw_q [$];
   logic [35:0] w_q [$];
   logic [31:0] cur_aw;
   logic [35:0] cur_w;
   logic [31:0] mem [logic [31:0]];

   // Handshake monitor; slave memory is updated when B completes.
   always @(posedge cpu_clk) begin
      logic [31:0] word;
      cyc++;
      if (m_awvalid && m_awready) begin
         cur_aw = m_awaddr;
         aw_q.push_back(m_awaddr);
      end
      if (m_wvalid && m_wready) begin
         cur_w = {m_wstrb, m_wdata};
         w_q.push_back({m_wstrb, m_wdata});
      end
      if (m_bvalid && m_bready) begin
         b_cnt++;
         b_cyc = cyc;
         word = mem.exists(cur_aw) ? mem[cur_aw] : 32'h0;
         for (int i = 0; i < 4; i++)
            if (cur_w[32+i]) word[8*i +: 8] = cur_w[8*i +: 8];
         mem[cur_aw] = word;
      end
      if (m_arvalid && m_arready) ar_cyc = cyc;
   end

   // B channel responder with programmable delay.
   initial forever begin
      @(negedge cpu_clk);
      if (m_bready && !m_bvalid) begin
         repeat (b_delay) @(negedge cpu_clk);
         m_bresp  = bresp_cfg;
         m_bvalid = 1'b1;
         @(negedge cpu_clk);
         m_bvalid = 1'b0;
         m_bresp  = 2'b00;
      end
   end

   // R channel responder; r_hold keeps it silent.
   initial forever begin
      @(negedge cpu_clk);
      if (m_rready && !m_rvalid && !r_hold) begin
         m_rdata  = mem.exists(m_araddr) ? mem[m_araddr] : 32'h0;
         m_rresp  = rresp_cfg;
         m_rvalid = 1'b1;
         @(negedge cpu_clk);
         m_rvalid = 1'b0;
         m_rresp  = 2'b00;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic store(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
      int n;
      n = 0;
      DAXI_access      = 1'b1;
      DAXI_rd0_wr1     = 1'b1;
      DAXI_addr        = a;
      DAXI_write_data  = d;
      DAXI_byte_strobe = s;
      while (DAXI_trans_buffer_full && n < 200) begin
         @(negedge cpu_clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL store_accept got full=1 exp full=0 addr=%h", a);
      end
      @(negedge cpu_clk);
      DAXI_access  = 1'b0;
      DAXI_rd0_wr1 = 1'b0;
   endtask

   task automatic load(input logic [31:0] a, output logic [31:0] d,
                       output int lat);
      DAXI_access  = 1'b1;
      DAXI_rd0_wr1 = 1'b0;
      DAXI_addr    = a;
      @(negedge cpu_clk);
      DAXI_access = 1'b0;
      lat = 1;
      while (!DAXI_read_data_valid && lat < 100) begin
         @(negedge cpu_clk);
         lat++;
      end
      checks++;
      if (DAXI_read_data_valid !== 1'b1) begin
         errors++;
         $display("FAIL load_timeout got valid=%b exp 1 addr=%h", DAXI_read_data_valid, a);
      end
      d = DAXI_read_data;
      @(negedge cpu_clk);
      checks++;
      if (DAXI_read_data_valid !== 1'b0) begin
         errors++;
         $display("FAIL load_pulse got valid=%b exp 0", DAXI_read_data_valid);
      end
   endtask

   task automatic wait_b(input int target);
      int n;
      n = 0;
      while (b_cnt < target && n < 200) begin
         @(negedge cpu_clk);
         n++;
      end
      checks++;
      if (b_cnt < target) begin
         errors++;
         $display("FAIL b_timeout got %0d exp %0d", b_cnt, target);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      checks++;
      if ({DAXI_trans_buffer_full, DAXI_read_data_valid} !== 2'b00) begin
         errors++;
         $display("FAIL %s_flags got %b exp 00", tag,
                  {DAXI_trans_buffer_full, DAXI_read_data_valid});
      end
      checks++;
      if (DAXI_read_data !== 32'h0) begin
         errors++;
         $display("FAIL %s_rdata got %h exp 0", tag, DAXI_read_data);
      end
      checks++;
      if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 5'b0) begin
         errors++;
         $display("FAIL %s_axi_ctl got %b exp 00000", tag,
                  {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready});
      end
      checks++;
      if ({m_awaddr, m_araddr, m_wdata, m_wstrb} !== 100'h0) begin
         errors++;
         $display("FAIL %s_axi_payload got %h exp 0", tag,
                  {m_awaddr, m_araddr, m_wdata, m_wstrb});
      end
      checks++;
      if ({daxi_err, daxi_err_addr} !== 33'h0) begin
         errors++;
         $display("FAIL %s_err got %h exp 0", tag, {daxi_err, daxi_err_addr});
      end
   endtask

   task automatic test_reset();
      cpu_rstn = 1'b0;
      repeat (2) @(negedge cpu_clk);
      check_idle_outputs("reset");
      cpu_rstn = 1'b1;
      @(negedge cpu_clk);
   endtask

   task automatic test_single_store();
      int base;
      base = b_cnt;
      aw_q.delete();
      w_q.delete();
      store(32'h0000_1000, 32'hA5A5_A5A5, 4'hF);
      wait_b(base + 1);
      repeat (3) @(negedge cpu_clk);
      checks++;
      if ((aw_q.size() > 0 ? aw_q[0] : 32'hx) !== 32'h0000_1000) begin
         errors++;
         $display("FAIL t1_awaddr got %h exp 00001000", aw_q.size() > 0 ? aw_q[0] : 32'hx);
      end
      checks++;
      if ((w_q.size() > 0 ? w_q[0] : 36'hx) !== 36'hF_A5A5_A5A5) begin
         errors++;
         $display("FAIL t1_wbeat got %h exp fa5a5a5a5", w_q.size() > 0 ? w_q[0] : 36'hx);
      end
      checks++;
      if (aw_q.size() != 1 || w_q.size() != 1 || b_cnt != base + 1) begin
         errors++;
         $display("FAIL t1_counts got aw=%0d w=%0d b=%0d exp 1 1 1",
                  aw_q.size(), w_q.size(), b_cnt - base);
      end
      checks++;
      if ({DAXI_trans_buffer_full, m_awvalid, m_wvalid} !== 3'b000) begin
         errors++;
         $display("FAIL t1_empty got %b exp 000",
                  {DAXI_trans_buffer_full, m_awvalid, m_wvalid});
      end
   endtask

   task automatic test_buffer_full();
      logic [31:0] ta [5];
      logic [31:0] td [5];
      int base;
      ta = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
      td = '{32'hA000_0001, 32'hB000_0002, 32'hC000_0003,
             32'hD000_0004, 32'hE000_0005};
      base = b_cnt;
      aw_q.delete();
      w_q.delete();
      m_awready = 1'b0;
      for (int i = 0; i < 4; i++) store(ta[i], td[i], 4'hF);
      checks++;
      if (DAXI_trans_buffer_full !== 1'b1) begin
         errors++;
         $display("FAIL t2_full_after4 got %b exp 1", DAXI_trans_buffer_full);
      end
      fork
         store(ta[4], td[4], 4'hF);
         begin
            repeat (3) @(negedge cpu_clk);
            checks++;
            if (DAXI_trans_buffer_full !== 1'b1) begin
               errors++;
               $display("FAIL t2_full_held got %b exp 1", DAXI_trans_buffer_full);
            end
            checks++;
            if (aw_q.size() != 0 || w_q.size() != 1) begin
               errors++;
               $display("FAIL t2_stalled got aw=%0d w=%0d exp 0 1",
                        aw_q.size(), w_q.size());
            end
            m_awready = 1'b1;
         end
      join
      wait_b(base + 5);
      repeat (3) @(negedge cpu_clk);
      checks++;
      if (aw_q.size() != 5 || w_q.size() != 5) begin
         errors++;
         $display("FAIL t2_counts got aw=%0d w=%0d exp 5 5", aw_q.size(), w_q.size());
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ((aw_q.size() > i ? aw_q[i] : 32'hx) !== ta[i]) begin
            errors++;
            $display("FAIL t2_awaddr%0d got %h exp %h", i,
                     aw_q.size() > i ? aw_q[i] : 32'hx, ta[i]);
         end
         checks++;
         if ((w_q.size() > i ? w_q[i] : 36'hx) !== {4'hF, td[i]}) begin
            errors++;
            $display("FAIL t2_wbeat%0d got %h exp %h", i,
                     w_q.size() > i ? w_q[i] : 36'hx, {4'hF, td[i]});
         end
      end
   endtask

   task automatic test_load_after_store();
      logic [31:0] d;
      int lat;
      b_delay = 3;
      store(32'h0000_2000, 32'h1234_5678, 4'hF);
      load(32'h0000_2000, d, lat);
      b_delay = 0;
      checks++;
      if (d !== 32'h1234_5678) begin
         errors++;
         $display("FAIL t3_rdata got %h exp 12345678", d);
      end
      checks++;
      if (ar_cyc <= b_cyc) begin
         errors++;
         $display("FAIL t3_order got ar_cyc=%0d exp > b_cyc=%0d", ar_cyc, b_cyc);
      end
   endtask

   task automatic test_w_before_aw();
      logic [31:0] d;
      int base;
      int lat;
      base = b_cnt;
      aw_q.delete();
      w_q.delete();
      m_awready = 1'b0;
      store(32'h0000_4000, 32'hDEAD_BEEF, 4'h3);
      repeat (3) @(negedge cpu_clk);
      m_awready = 1'b1;
      wait_b(base + 1);
      repeat (4) @(negedge cpu_clk);
      checks++;
      if (aw_q.size() != 1 || w_q.size() != 1 || b_cnt != base + 1) begin
         errors++;
         $display("FAIL t4_counts got aw=%0d w=%0d b=%0d exp 1 1 1",
                  aw_q.size(), w_q.size(), b_cnt - base);
      end
      checks++;
      if ((w_q.size() > 0 ? w_q[0] : 36'hx) !== 36'h3_DEAD_BEEF) begin
         errors++;
         $display("FAIL t4_wbeat got %h exp 3deadbeef", w_q.size() > 0 ? w_q[0] : 36'hx);
      end
      load(32'h0000_4000, d, lat);
      checks++;
      if (d !== 32'h0000_BEEF) begin
         errors++;
         $display("FAIL t4_strobe_rdata got %h exp 0000beef", d);
      end
      checks++;
      if (lat != 4) begin
         errors++;
         $display("FAIL t4_latency got %0d exp 4", lat);
      end
   endtask

   task automatic test_reset_in_rdata();
      logic [31:0] d;
      int lat;
      int n;
      r_hold       = 1'b1;
      DAXI_access  = 1'b1;
      DAXI_rd0_wr1 = 1'b0;
      DAXI_addr    = 32'h0000_1000;
      @(negedge cpu_clk);
      DAXI_access = 1'b0;
      n = 0;
      while (!m_rready && n < 50) begin
         @(negedge cpu_clk);
         n++;
      end
      checks++;
      if (m_rready !== 1'b1) begin
         errors++;
         $display("FAIL t5_reach_rdata got rready=%b exp 1", m_rready);
      end
      cpu_rstn = 1'b0;
      #1;
      check_idle_outputs("t5_reset");
      repeat (2) @(negedge cpu_clk);
      r_hold   = 1'b0;
      cpu_rstn = 1'b1;
      @(negedge cpu_clk);
      load(32'h0000_2000, d, lat);
      checks++;
      if (d !== 32'h1234_5678) begin
         errors++;
         $display("FAIL t5_rdata got %h exp 12345678", d);
      end
      checks++;
      if (lat != 4) begin
         errors++;
         $display("FAIL t5_latency got %0d exp 4", lat);
      end
   endtask

   task automatic test_err_capture();
      logic [31:0] d;
      int base;
      int lat;
      base = b_cnt;
      bresp_cfg = 2'b10;
      store(32'h0000_3004, 32'hCAFE_F00D, 4'hF);
      wait_b(base + 1);
      bresp_cfg = 2'b00;
      repeat (2) @(negedge cpu_clk);
`ifdef KRV_DAXI_ERR_CAPTURE_EN
      checks++;
      if ({daxi_err, daxi_err_addr} !== {1'b1, 32'h0000_3004}) begin
         errors++;
         $display("FAIL t6_berr got %h exp 100003004", {daxi_err, daxi_err_addr});
      end
      rresp_cfg = 2'b10;
      load(32'h0000_1000, d, lat);
      rresp_cfg = 2'b00;
      checks++;
      if (d !== 32'hA5A5_A5A5) begin
         errors++;
         $display("FAIL t6_rdata got %h exp a5a5a5a5", d);
      end
      checks++;
      if ({daxi_err, daxi_err_addr} !== {1'b1, 32'h0000_3004}) begin
         errors++;
         $display("FAIL t6_rerr_keep got %h exp 100003004", {daxi_err, daxi_err_addr});
      end
`else
      checks++;
      if ({daxi_err, daxi_err_addr} !== 33'h0) begin
         errors++;
         $display("FAIL t6_err_off got %h exp 0", {daxi_err, daxi_err_addr});
      end
      rresp_cfg = 2'b10;
      load(32'h0000_1000, d, lat);
      rresp_cfg = 2'b00;
      checks++;
      if (d !== 32'hA5A5_A5A5) begin
         errors++;
         $display("FAIL t6_rdata got %h exp a5a5a5a5", d);
      end
`endif
   endtask

   initial begin
      @(negedge cpu_clk);
      test_reset();
      test_single_store();
      test_buffer_full();
      test_load_after_store();
      test_w_before_aw();
      test_reset_in_rdata();
      test_err_capture();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
